pipe_stage_regs: RTL and testbench

- Bundles the three forward pipeline registers of the 5-stage ARMv8 CPU: IF/ID, ID/EX and EX/MEM.
- Each bank captures its stage's datapath values and control bits on the rising clock edge and presents them to the next stage one cycle later.
- MEM/WB is a separate block.
- Per-bank enable (stall) and flush (bubble) inputs give hazard logic a single point of control.

---
 rtl/pipe_stage_regs.sv | 127 ++++++++++++
 tb/tb_pipe_stage_regs.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_regs.sv
// IF/ID, ID/EX and EX/MEM pipeline banks: 1-cycle latency, every output registered.
// No handshake; per-bank enable holds (stall) and flush clears (bubble), flush wins.
module pipe_stage_regs #(
  parameter int DW = 64,
  parameter int IW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    en,
  input  logic [2:0]    flush,
  input  logic [DW-1:0] ifid_pc_d,
  input  logic [IW-1:0] ifid_inst_d,
  output logic [DW-1:0] ifid_pc_q,
  output logic [IW-1:0] ifid_inst_q,
  input  logic [DW-1:0] idex_rda_d,
  input  logic [DW-1:0] idex_rdb_d,
  input  logic [RW-1:0] idex_rd_d,
  input  logic [RW-1:0] idex_rn_d,
  input  logic [RW-1:0] idex_rm_d,
  input  logic [DW-1:0] idex_pc_d,
  input  logic [DW-1:0] idex_imm_d,
  input  logic [11:0]   idex_ctrl_d,
  output logic [DW-1:0] idex_rda_q,
  output logic [DW-1:0] idex_rdb_q,
  output logic [RW-1:0] idex_rd_q,
  output logic [RW-1:0] idex_rn_q,
  output logic [RW-1:0] idex_rm_q,
  output logic [DW-1:0] idex_pc_q,
  output logic [DW-1:0] idex_imm_q,
  output logic [11:0]   idex_ctrl_q,
  input  logic [DW-1:0] exmem_alu_d,
  input  logic [DW-1:0] exmem_sdata_d,
  input  logic [RW-1:0] exmem_rd_d,
  input  logic [2:0]    exmem_flags_d,
  input  logic [DW-1:0] exmem_target_d,
  input  logic [6:0]    exmem_ctrl_d,
  output logic [DW-1:0] exmem_alu_q,
  output logic [DW-1:0] exmem_sdata_q,
  output logic [RW-1:0] exmem_rd_q,
  output logic [2:0]    exmem_flags_q,
  output logic [DW-1:0] exmem_target_q,
  output logic [6:0]    exmem_ctrl_q
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [IW-1:0] inst;
  } ifid_t;

  typedef struct packed {
    logic [DW-1:0] rda;
    logic [DW-1:0] rdb;
    logic [RW-1:0] rd;
    logic [RW-1:0] rn;
    logic [RW-1:0] rm;
    logic [DW-1:0] pc;
    logic [DW-1:0] imm;
    logic [11:0]   ctrl;
  } idex_t;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] sdata;
    logic [RW-1:0] rd;
    logic [2:0]    flags;
    logic [DW-1:0] target;
    logic [6:0]    ctrl;
  } exmem_t;

  ifid_t  ifid_d,  ifid_q;
  idex_t  idex_d,  idex_q;
  exmem_t exmem_d, exmem_q;

  // A cleared bank is a bubble: inst 0 and all control bits low.
  always_comb begin
    ifid_d = ifid_q;
    if (flush[2])   ifid_d = '0;
    else if (en[2]) ifid_d = '{pc: ifid_pc_d, inst: ifid_inst_d};
  end

  always_comb begin
    idex_d = idex_q;
    if (flush[1])   idex_d = '0;
    else if (en[1]) idex_d = '{rda: idex_rda_d, rdb: idex_rdb_d, rd: idex_rd_d,
                               rn: idex_rn_d, rm: idex_rm_d, pc: idex_pc_d,
                               imm: idex_imm_d, ctrl: idex_ctrl_d};
  end

  always_comb begin
    exmem_d = exmem_q;
    if (flush[0])   exmem_d = '0;
    else if (en[0]) exmem_d = '{alu: exmem_alu_d, sdata: exmem_sdata_d, rd: exmem_rd_d,
                                flags: exmem_flags_d, target: exmem_target_d,
                                ctrl: exmem_ctrl_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end

  assign ifid_pc_q      = ifid_q.pc;
  assign ifid_inst_q    = ifid_q.inst;
  assign idex_rda_q     = idex_q.rda;
  assign idex_rdb_q     = idex_q.rdb;
  assign idex_rd_q      = idex_q.rd;
  assign idex_rn_q      = idex_q.rn;
  assign idex_rm_q      = idex_q.rm;
  assign idex_pc_q      = idex_q.pc;
  assign idex_imm_q     = idex_q.imm;
  assign idex_ctrl_q    = idex_q.ctrl;
  assign exmem_alu_q    = exmem_q.alu;
  assign exmem_sdata_q  = exmem_q.sdata;
  assign exmem_rd_q     = exmem_q.rd;
  assign exmem_flags_q  = exmem_q.flags;
  assign exmem_target_q = exmem_q.target;
  assign exmem_ctrl_q   = exmem_q.ctrl;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: reset, pass-through, stall, flush and full-width capture.
module tb_pipe_stage_regs;
  localparam int DW = 64;
  localparam int IW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    en, flush;
  logic [DW-1:0] ifid_pc_d, ifid_pc_q;
  logic [IW-1:0] ifid_inst_d, ifid_inst_q;
  logic [DW-1:0] idex_rda_d, idex_rda_q, idex_rdb_d, idex_rdb_q;
  logic [RW-1:0] idex_rd_d, idex_rd_q, idex_rn_d, idex_rn_q, idex_rm_d, idex_rm_q;
  logic [DW-1:0] idex_pc_d, idex_pc_q, idex_imm_d, idex_imm_q;
  logic [11:0]   idex_ctrl_d, idex_ctrl_q;
  logic [DW-1:0] exmem_alu_d, exmem_alu_q, exmem_sdata_d, exmem_sdata_q;
  logic [RW-1:0] exmem_rd_d, exmem_rd_q;
  logic [2:0]    exmem_flags_d, exmem_flags_q;
  logic [DW-1:0] exmem_target_d, exmem_target_q;
  logic [6:0]    exmem_ctrl_d, exmem_ctrl_q;

  int n_vec = 0;
  int n_bad = 0;
  bit salt  = 1'b1;

  always #5 clk = ~clk;

  pipe_stage_regs #(.DW(DW), .IW(IW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .ifid_pc_d(ifid_pc_d), .ifid_inst_d(ifid_inst_d),
    .ifid_pc_q(ifid_pc_q), .ifid_inst_q(ifid_inst_q),
    .idex_rda_d(idex_rda_d), .idex_rdb_d(idex_rdb_d), .idex_rd_d(idex_rd_d),
    .idex_rn_d(idex_rn_d), .idex_rm_d(idex_rm_d), .idex_pc_d(idex_pc_d),
    .idex_imm_d(idex_imm_d), .idex_ctrl_d(idex_ctrl_d),
    .idex_rda_q(idex_rda_q), .idex_rdb_q(idex_rdb_q), .idex_rd_q(idex_rd_q),
    .idex_rn_q(idex_rn_q), .idex_rm_q(idex_rm_q), .idex_pc_q(idex_pc_q),
    .idex_imm_q(idex_imm_q), .idex_ctrl_q(idex_ctrl_q),
    .exmem_alu_d(exmem_alu_d), .exmem_sdata_d(exmem_sdata_d), .exmem_rd_d(exmem_rd_d),
    .exmem_flags_d(exmem_flags_d), .exmem_target_d(exmem_target_d),
    .exmem_ctrl_d(exmem_ctrl_d),
    .exmem_alu_q(exmem_alu_q), .exmem_sdata_q(exmem_sdata_q), .exmem_rd_q(exmem_rd_q),
    .exmem_flags_q(exmem_flags_q), .exmem_target_q(exmem_target_q),
    .exmem_ctrl_q(exmem_ctrl_q)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-field variant of a pattern so that swapped or crossed fields are visible.
  function automatic logic [63:0] fv(input logic [63:0] v, input int k);
    return salt ? v ^ (64'(k) * 64'h0101_0101_0101_0101) : v;
  endfunction

  task automatic set_d(input logic [63:0] v);
    logic [63:0] t;
    ifid_pc_d      = fv(v, 1);
    t = fv(v, 2);  ifid_inst_d   = t[31:0];
    idex_rda_d     = fv(v, 3);
    idex_rdb_d     = fv(v, 4);
    t = fv(v, 5);  idex_rd_d     = t[4:0];
    t = fv(v, 6);  idex_rn_d     = t[4:0];
    t = fv(v, 7);  idex_rm_d     = t[4:0];
    idex_pc_d      = fv(v, 8);
    idex_imm_d     = fv(v, 9);
    t = fv(v, 10); idex_ctrl_d   = t[11:0];
    exmem_alu_d    = fv(v, 11);
    exmem_sdata_d  = fv(v, 12);
    t = fv(v, 13); exmem_rd_d    = t[4:0];
    t = fv(v, 14); exmem_flags_d = t[2:0];
    exmem_target_d = fv(v, 15);
    t = fv(v, 16); exmem_ctrl_d  = t[6:0];
  endtask

  task automatic chk_ifid(input string t, input logic [63:0] v);
    logic [63:0] e;
    chk({t, ".ifid_pc"}, ifid_pc_q, fv(v, 1));
    e = fv(v, 2);  chk({t, ".ifid_inst"}, 64'(ifid_inst_q), 64'(e[31:0]));
  endtask

  task automatic chk_idex(input string t, input logic [63:0] v);
    logic [63:0] e;
    chk({t, ".idex_rda"}, idex_rda_q, fv(v, 3));
    chk({t, ".idex_rdb"}, idex_rdb_q, fv(v, 4));
    e = fv(v, 5);  chk({t, ".idex_rd"}, 64'(idex_rd_q), 64'(e[4:0]));
    e = fv(v, 6);  chk({t, ".idex_rn"}, 64'(idex_rn_q), 64'(e[4:0]));
    e = fv(v, 7);  chk({t, ".idex_rm"}, 64'(idex_rm_q), 64'(e[4:0]));
    chk({t, ".idex_pc"}, idex_pc_q, fv(v, 8));
    chk({t, ".idex_imm"}, idex_imm_q, fv(v, 9));
    e = fv(v, 10); chk({t, ".idex_ctrl"}, 64'(idex_ctrl_q), 64'(e[11:0]));
  endtask

  task automatic chk_exmem(input string t, input logic [63:0] v);
    logic [63:0] e;
    chk({t, ".exmem_alu"}, exmem_alu_q, fv(v, 11));
    chk({t, ".exmem_sdata"}, exmem_sdata_q, fv(v, 12));
    e = fv(v, 13); chk({t, ".exmem_rd"}, 64'(exmem_rd_q), 64'(e[4:0]));
    e = fv(v, 14); chk({t, ".exmem_flags"}, 64'(exmem_flags_q), 64'(e[2:0]));
    chk({t, ".exmem_target"}, exmem_target_q, fv(v, 15));
    e = fv(v, 16); chk({t, ".exmem_ctrl"}, 64'(exmem_ctrl_q), 64'(e[6:0]));
  endtask

  task automatic chk_zero(input string t);
    bit s;
    s = salt;
    salt = 1'b0;
    chk_ifid(t, 64'h0);
    chk_idex(t, 64'h0);
    chk_exmem(t, 64'h0);
    salt = s;
  endtask

  task automatic chk_all(input string t, input logic [63:0] v);
    chk_ifid(t, v);
    chk_idex(t, v);
    chk_exmem(t, v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    en    = 3'b111;
    flush = 3'b000;
    set_d(64'hA5A5_5A5A_1234_5678);

    // Held in reset across two edges with nonzero inputs.
    #23 chk_zero("rst_hold");
    #4  reset = 1'b1;
    #1  chk_zero("rst_release");
    tick();
    chk_all("first_load", 64'hA5A5_5A5A_1234_5678);

    // Asynchronous reset between edges clears everything at once.
    set_d(64'h0F0F_F0F0_8765_4321);
    #2 reset = 1'b0;
    #1 chk_zero("rst_async");
    #1 reset = 1'b1;
    #1 chk_zero("rst_async_rel");
    tick();
    chk_all("post_rst_load", 64'h0F0F_F0F0_8765_4321);

    // Pass-through with exact one-edge latency.
    ifid_pc_d   = 64'h4;
    ifid_inst_d = 32'h8B02_0020;
    tick();
    chk("pt_pc0", ifid_pc_q, 64'h4);
    chk("pt_inst0", 64'(ifid_inst_q), 64'h8B02_0020);
    ifid_pc_d   = 64'h8;
    ifid_inst_d = 32'h8B03_0041;
    #2 chk("pt_pc_no_comb", ifid_pc_q, 64'h4);
    tick();
    chk("pt_pc1", ifid_pc_q, 64'h8);
    chk("pt_inst1", 64'(ifid_inst_q), 64'h8B03_0041);

    // Control bundles and flags.
    idex_ctrl_d   = 12'hA5C;
    exmem_ctrl_d  = 7'h55;
    exmem_flags_d = 3'b101;
    tick();
    chk("ctl_idex", 64'(idex_ctrl_q), 64'hA5C);
    chk("ctl_exmem", 64'(exmem_ctrl_q), 64'h55);
    chk("ctl_flags", 64'(exmem_flags_q), 64'h5);
    for (int i = 0; i < 12; i++) begin
      idex_ctrl_d   = 12'h001 << i;
      exmem_ctrl_d  = 7'h01 << (i % 7);
      exmem_flags_d = 3'b001 << (i % 3);
      tick();
      chk($sformatf("walk_idex%0d", i), 64'(idex_ctrl_q), 64'h1 << i);
      chk($sformatf("walk_exmem%0d", i), 64'(exmem_ctrl_q), 64'h1 << (i % 7));
      chk($sformatf("walk_flags%0d", i), 64'(exmem_flags_q), 64'h1 << (i % 3));
    end

    // Stall IF/ID for three edges while the other banks keep moving.
    ifid_pc_d = 64'h20;
    tick();
    en = 3'b011;
    for (int k = 0; k < 3; k++) begin
      ifid_pc_d   = 64'h8 + 64'(4 * k);
      exmem_alu_d = 64'h100 + 64'(k);
      idex_pc_d   = 64'h200 + 64'(k);
      tick();
      chk($sformatf("stall_ifid%0d", k), ifid_pc_q, 64'h20);
      chk($sformatf("stall_exmem%0d", k), exmem_alu_q, 64'h100 + 64'(k));
      chk($sformatf("stall_idex%0d", k), idex_pc_q, 64'h200 + 64'(k));
    end
    en = 3'b111;
    tick();
    chk("stall_resume", ifid_pc_q, 64'h10);

    // Flush overrides enable on ID/EX; neighbours still load.
    set_d(64'h0123_4567_89AB_CDEF);
    tick();
    chk_idex("pre_flush", 64'h0123_4567_89AB_CDEF);
    set_d(64'h0000_0000_DEAD_BEEF);
    idex_ctrl_d = 12'hFFF;
    flush = 3'b010;
    tick();
    chk_zero_idex: begin
      bit s;
      s = salt;
      salt = 1'b0;
      chk_idex("flush_idex", 64'h0);
      salt = s;
    end
    chk_ifid("flush_ifid", 64'h0000_0000_DEAD_BEEF);
    chk_exmem("flush_exmem", 64'h0000_0000_DEAD_BEEF);

    // Flush of EX/MEM while it is also stalled; others load.
    set_d(64'h7777_8888_9999_AAAA);
    en    = 3'b110;
    flush = 3'b001;
    tick();
    chk("flush_stall_alu", exmem_alu_q, 64'h0);
    chk("flush_stall_ctrl", 64'(exmem_ctrl_q), 64'h0);
    chk_ifid("flush2_ifid", 64'h7777_8888_9999_AAAA);
    chk_idex("flush2_idex", 64'h7777_8888_9999_AAAA);
    en    = 3'b111;
    flush = 3'b000;

    // Full-width capture of all ones, then all zeros.
    salt = 1'b0;
    set_d(64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk_all("ones", 64'hFFFF_FFFF_FFFF_FFFF);
    set_d(64'h0);
    tick();
    chk_all("zeros", 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
